usb_config_word_packer: RTL and testbench



---
 rtl/usb_config_packer_pkg.sv | 26 ++
 rtl/usb_config_word_packer_word_assembler.sv | 52 +++++
 rtl/usb_config_word_packer.sv | 208 ++++++++++++++++++++
 tb/tb_usb_config_word_packer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_config_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_config_packer_pkg
//  Description : Shared types and constants for the USB configuration word
//                packer (state encoding, default sync marker, header fields).
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_config_packer_pkg;

   // Packet parser states; ST_CHECK is only reachable with the checksum build
   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_HEADER = 2'd1,
      ST_DATA   = 2'd2,
      ST_CHECK  = 2'd3
   } state_t;

   // Default packet start marker
   localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

   // Bit positions of the payload length field inside the header word
   localparam int HDR_LEN_MSB = 15;
   localparam int HDR_LEN_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/usb_config_word_packer_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : word_assembler
//  Description : 8-to-32 big-endian byte packer. Keeps the last three bytes
//                so that {history, incoming byte} forms the 32-bit window,
//                flags the 4th byte of each word, and can be cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_assembler (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   // Oldest byte ends up in [31:24]; the newest byte is taken live from byte_i
   logic [23:0] shift_q, shift_d;
   logic [1:0]  cnt_q, cnt_d;

   // The window includes the byte being accepted this cycle
   assign word_o       = {shift_q, byte_i};
   assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

   // Next-state: clear wins over an incoming byte so no partial word survives
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (clear_i) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (byte_valid_i) begin
         shift_d = {shift_q[15:0], byte_i};
         cnt_d   = cnt_q + 2'd1;
      end
   end

   // Shift history and byte counter registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/usb_config_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : usb_config_word_packer
//  Description : Parses sync / header / payload packets from the USB byte
//                stream and strobes payload words to the fabric self-write
//                port. Optional trailer checksum: define PACKER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_config_word_packer
   import usb_config_packer_pkg::*;
#(
   parameter logic [31:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk_system_i,
   input  logic        reset_i,
   input  logic [7:0]  byte_data_i,
   input  logic        byte_valid_i,
   output logic        byte_ready_o,
   output logic [31:0] write_data_o,
   output logic        write_strobe_o,
   output logic        active_o,
   output logic        done_o,
   output logic [15:0] word_count_o,
   output logic        timeout_error_o,
   output logic        checksum_error_o
);

   localparam logic [31:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES;

   state_t      state_q, state_d;
   logic        ready_q, ready_d;
   logic [31:0] wdata_q, wdata_d;
   logic        strobe_q, strobe_d;
   logic        active_q, active_d;
   logic        done_q, done_d;
   logic [15:0] count_q, count_d;
   logic [15:0] remaining_q, remaining_d;
   logic [31:0] idle_q, idle_d;
   logic        terr_q, terr_d;
`ifdef PACKER_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;
   logic        cerr_q, cerr_d;
`endif

   logic        hs;
   logic        asm_clear;
   logic [31:0] asm_word;
   logic        asm_word_valid;

   assign hs = byte_valid_i && ready_q;

   word_assembler u_word_assembler (
      .clk_i        (clk_system_i),
      .rst_i        (reset_i),
      .clear_i      (asm_clear),
      .byte_valid_i (hs),
      .byte_i       (byte_data_i),
      .word_o       (asm_word),
      .word_valid_o (asm_word_valid)
   );

   // Packet parser: sync hunt, header decode, payload strobes, timeout abort
   always_comb begin
      state_d     = state_q;
      ready_d     = 1'b1;
      wdata_d     = wdata_q;
      strobe_d    = 1'b0;
      active_d    = active_q;
      done_d      = 1'b0;
      count_d     = count_q;
      remaining_d = remaining_q;
      idle_d      = '0;
      terr_d      = terr_q;
      asm_clear   = 1'b0;
`ifdef PACKER_CHECKSUM_EN
      sum_d       = sum_q;
      cerr_d      = cerr_q;
`endif
      case (state_q)
         ST_HUNT: begin
            if (hs && (asm_word == SYNC_WORD)) begin
               state_d   = ST_HEADER;
               active_d  = 1'b1;
               count_d   = '0;
               terr_d    = 1'b0;
               asm_clear = 1'b1;
`ifdef PACKER_CHECKSUM_EN
               sum_d     = '0;
               cerr_d    = 1'b0;
`endif
            end
         end
         ST_HEADER: begin
            if (hs && asm_word_valid) begin
               if (asm_word[HDR_LEN_MSB:HDR_LEN_LSB] == 16'd0) begin
                  state_d   = ST_HUNT;
                  done_d    = 1'b1;
                  active_d  = 1'b0;
                  asm_clear = 1'b1;
               end else begin
                  state_d     = ST_DATA;
                  remaining_d = asm_word[HDR_LEN_MSB:HDR_LEN_LSB];
               end
            end
         end
         ST_DATA: begin
            if (hs && asm_word_valid) begin
               wdata_d     = asm_word;
               strobe_d    = 1'b1;
               remaining_d = remaining_q - 16'd1;
               if (count_q != 16'hFFFF)
                  count_d = count_q + 16'd1;
`ifdef PACKER_CHECKSUM_EN
               sum_d = sum_q + asm_word;
               if (remaining_q == 16'd1)
                  state_d = ST_CHECK;
`else
               if (remaining_q == 16'd1) begin
                  state_d   = ST_HUNT;
                  done_d    = 1'b1;
                  active_d  = 1'b0;
                  asm_clear = 1'b1;
               end
`endif
            end
         end
`ifdef PACKER_CHECKSUM_EN
         ST_CHECK: begin
            if (hs && asm_word_valid) begin
               state_d   = ST_HUNT;
               done_d    = 1'b1;
               active_d  = 1'b0;
               asm_clear = 1'b1;
               cerr_d    = (asm_word != sum_q);
            end
         end
`endif
         default: begin
            state_d   = ST_HUNT;
            active_d  = 1'b0;
            asm_clear = 1'b1;
         end
      endcase

      // Idle watchdog inside a packet; a handshake leaves idle_d at zero
      if ((state_q != ST_HUNT) && !hs && (TIMEOUT_LIMIT != 32'd0)) begin
         idle_d = idle_q + 32'd1;
         if (idle_d == TIMEOUT_LIMIT) begin
            state_d   = ST_HUNT;
            terr_d    = 1'b1;
            active_d  = 1'b0;
            asm_clear = 1'b1;
            idle_d    = '0;
         end
      end
   end

   // State and registered outputs
   always_ff @(posedge clk_system_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_HUNT;
         ready_q     <= 1'b0;
         wdata_q     <= '0;
         strobe_q    <= 1'b0;
         active_q    <= 1'b0;
         done_q      <= 1'b0;
         count_q     <= '0;
         remaining_q <= '0;
         idle_q      <= '0;
         terr_q      <= 1'b0;
`ifdef PACKER_CHECKSUM_EN
         sum_q       <= '0;
         cerr_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         wdata_q     <= wdata_d;
         strobe_q    <= strobe_d;
         active_q    <= active_d;
         done_q      <= done_d;
         count_q     <= count_d;
         remaining_q <= remaining_d;
         idle_q      <= idle_d;
         terr_q      <= terr_d;
`ifdef PACKER_CHECKSUM_EN
         sum_q       <= sum_d;
         cerr_q      <= cerr_d;
`endif
      end
   end

   assign byte_ready_o    = ready_q;
   assign write_data_o    = wdata_q;
   assign write_strobe_o  = strobe_q;
   assign active_o        = active_q;
   assign done_o          = done_q;
   assign word_count_o    = count_q;
   assign timeout_error_o = terr_q;
`ifdef PACKER_CHECKSUM_EN
   assign checksum_error_o = cerr_q;
`else
   assign checksum_error_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_config_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_config_word_packer
//  Description : Directed vector bench for usb_config_word_packer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_config_word_packer;

`ifdef PACKER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  byte_data = '0;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic [31:0] write_data;
   logic        write_strobe;
   logic        active;
   logic        done;
   logic [15:0] word_count;
   logic        timeout_error;
   logic        checksum_error;

   int n_checks = 0;
   int n_fail   = 0;
   int strobe_cnt = 0;
   int snap;

   usb_config_word_packer #(
      .SYNC_WORD      (32'hFAB0_FAB1),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_system_i     (clk),
      .reset_i          (rst),
      .byte_data_i      (byte_data),
      .byte_valid_i     (byte_valid),
      .byte_ready_o     (byte_ready),
      .write_data_o     (write_data),
      .write_strobe_o   (write_strobe),
      .active_o         (active),
      .done_o           (done),
      .word_count_o     (word_count),
      .timeout_error_o  (timeout_error),
      .checksum_error_o (checksum_error)
   );

   always #5 clk = ~clk;

   // Count strobe pulses mid-cycle
   always @(negedge clk) if (write_strobe === 1'b1) strobe_cnt++;

   typedef struct {
      logic        valid;
      logic [7:0]  data;
      logic        strobe;
      logic [31:0] wdata;
      logic        done;
      logic        active;
      logic [15:0] count;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, input logic [7:0] d, input logic s,
                      input logic [31:0] wd, input logic dn, input logic a,
                      input logic [15:0] c);
      vec_t e;
      e.valid = v; e.data = d; e.strobe = s; e.wdata = wd;
      e.done = dn; e.active = a; e.count = c;
      tbl.push_back(e);
   endtask

   // Trailer bytes (checksum build only): last byte ends the packet
   task automatic add_trailer(input logic [31:0] t, input logic [31:0] wd,
                              input logic [15:0] c);
      add(1, t[31:24], 0, wd, 0, 1, c);
      add(1, t[23:16], 0, wd, 0, 1, c);
      add(1, t[15:8],  0, wd, 0, 1, c);
      add(1, t[7:0],   0, wd, 1, 0, c);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
   endtask

   initial begin
      // ---------------- vector table ----------------
      // A: two-word packet, back-to-back bytes
      add(1, 8'hFA, 0, 32'h0, 0, 0, 0);
      add(1, 8'hB0, 0, 32'h0, 0, 0, 0);
      add(1, 8'hFA, 0, 32'h0, 0, 0, 0);
      add(1, 8'hB1, 0, 32'h0, 0, 1, 0);
      add(1, 8'h00, 0, 32'h0, 0, 1, 0);
      add(1, 8'h00, 0, 32'h0, 0, 1, 0);
      add(1, 8'h00, 0, 32'h0, 0, 1, 0);
      add(1, 8'h02, 0, 32'h0, 0, 1, 0);
      add(1, 8'h11, 0, 32'h0, 0, 1, 0);
      add(1, 8'h22, 0, 32'h0, 0, 1, 0);
      add(1, 8'h33, 0, 32'h0, 0, 1, 0);
      add(1, 8'h44, 1, 32'h11223344, 0, 1, 1);
      add(1, 8'h55, 0, 32'h11223344, 0, 1, 1);
      add(1, 8'h66, 0, 32'h11223344, 0, 1, 1);
      add(1, 8'h77, 0, 32'h11223344, 0, 1, 1);
      add(1, 8'h88, 1, 32'h55667788, !CK, CK, 2);
      if (CK) add_trailer(32'h6688AACC, 32'h55667788, 2);
      add(0, 8'h00, 0, 32'h55667788, 0, 0, 2);
      // B: sync at byte offset 2 after junk, length 1
      add(1, 8'h00, 0, 32'h55667788, 0, 0, 2);
      add(1, 8'hFA, 0, 32'h55667788, 0, 0, 2);
      add(1, 8'hFA, 0, 32'h55667788, 0, 0, 2);
      add(1, 8'hB0, 0, 32'h55667788, 0, 0, 2);
      add(1, 8'hFA, 0, 32'h55667788, 0, 0, 2);
      add(1, 8'hB1, 0, 32'h55667788, 0, 1, 0);
      add(1, 8'h00, 0, 32'h55667788, 0, 1, 0);
      add(1, 8'h00, 0, 32'h55667788, 0, 1, 0);
      add(1, 8'h00, 0, 32'h55667788, 0, 1, 0);
      add(1, 8'h01, 0, 32'h55667788, 0, 1, 0);
      add(1, 8'hDE, 0, 32'h55667788, 0, 1, 0);
      add(1, 8'hAD, 0, 32'h55667788, 0, 1, 0);
      add(1, 8'hBE, 0, 32'h55667788, 0, 1, 0);
      add(1, 8'hEF, 1, 32'hDEADBEEF, !CK, CK, 1);
      if (CK) add_trailer(32'hDEADBEEF, 32'hDEADBEEF, 1);
      // C: length 0 with nonzero upper header bits
      add(1, 8'hFA, 0, 32'hDEADBEEF, 0, 0, 1);
      add(1, 8'hB0, 0, 32'hDEADBEEF, 0, 0, 1);
      add(1, 8'hFA, 0, 32'hDEADBEEF, 0, 0, 1);
      add(1, 8'hB1, 0, 32'hDEADBEEF, 0, 1, 0);
      add(1, 8'hAB, 0, 32'hDEADBEEF, 0, 1, 0);
      add(1, 8'hCD, 0, 32'hDEADBEEF, 0, 1, 0);
      add(1, 8'h00, 0, 32'hDEADBEEF, 0, 1, 0);
      add(1, 8'h00, 0, 32'hDEADBEEF, 1, 0, 0);
      add(0, 8'h00, 0, 32'hDEADBEEF, 0, 0, 0);
      // D: sync pattern inside payload is plain data
      add(1, 8'hFA, 0, 32'hDEADBEEF, 0, 0, 0);
      add(1, 8'hB0, 0, 32'hDEADBEEF, 0, 0, 0);
      add(1, 8'hFA, 0, 32'hDEADBEEF, 0, 0, 0);
      add(1, 8'hB1, 0, 32'hDEADBEEF, 0, 1, 0);
      add(1, 8'h00, 0, 32'hDEADBEEF, 0, 1, 0);
      add(1, 8'h00, 0, 32'hDEADBEEF, 0, 1, 0);
      add(1, 8'h00, 0, 32'hDEADBEEF, 0, 1, 0);
      add(1, 8'h02, 0, 32'hDEADBEEF, 0, 1, 0);
      add(1, 8'hFA, 0, 32'hDEADBEEF, 0, 1, 0);
      add(1, 8'hB0, 0, 32'hDEADBEEF, 0, 1, 0);
      add(1, 8'hFA, 0, 32'hDEADBEEF, 0, 1, 0);
      add(1, 8'hB1, 1, 32'hFAB0FAB1, 0, 1, 1);
      add(1, 8'h01, 0, 32'hFAB0FAB1, 0, 1, 1);
      add(1, 8'h02, 0, 32'hFAB0FAB1, 0, 1, 1);
      add(1, 8'h03, 0, 32'hFAB0FAB1, 0, 1, 1);
      add(1, 8'h04, 1, 32'h01020304, !CK, CK, 2);
      if (CK) add_trailer(32'hFBB2FDB5, 32'h01020304, 2);
      add(0, 8'h00, 0, 32'h01020304, 0, 0, 2);

      // ---------------- reset values ----------------
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready",  {31'd0, byte_ready}, 32'd0);
      chk("rst_wdata",  write_data, 32'd0);
      chk("rst_strobe", {31'd0, write_strobe}, 32'd0);
      chk("rst_active", {31'd0, active}, 32'd0);
      chk("rst_done",   {31'd0, done}, 32'd0);
      chk("rst_count",  {16'd0, word_count}, 32'd0);
      chk("rst_terr",   {31'd0, timeout_error}, 32'd0);
      chk("rst_cerr",   {31'd0, checksum_error}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_rise", {31'd0, byte_ready}, 32'd1);

      // ---------------- table ----------------
      for (int i = 0; i < tbl.size(); i++) begin
         byte_valid = tbl[i].valid;
         byte_data  = tbl[i].data;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_strobe", i), {31'd0, write_strobe}, {31'd0, tbl[i].strobe});
         chk($sformatf("v%0d_wdata", i),  write_data, tbl[i].wdata);
         chk($sformatf("v%0d_done", i),   {31'd0, done}, {31'd0, tbl[i].done});
         chk($sformatf("v%0d_active", i), {31'd0, active}, {31'd0, tbl[i].active});
         chk($sformatf("v%0d_count", i),  {16'd0, word_count}, {16'd0, tbl[i].count});
      end
      byte_valid = 1'b0;

      // ---------------- timeout after 2 payload bytes ----------------
      send_word(32'hFAB0FAB1);
      send_word(32'h00000001);
      send(8'hAA);
      send(8'hBB);
      snap = strobe_cnt;
      repeat (15) @(posedge clk);
      #1;
      chk("to_terr_15",   {31'd0, timeout_error}, 32'd0);
      chk("to_active_15", {31'd0, active}, 32'd1);
      @(posedge clk);
      #1;
      chk("to_terr_16",   {31'd0, timeout_error}, 32'd1);
      chk("to_active_16", {31'd0, active}, 32'd0);
      chk("to_done_16",   {31'd0, done}, 32'd0);
      send(8'hCC);
      send(8'hDD);
      chk("to_no_strobe", strobe_cnt, snap);
      send_word(32'hFAB0FAB1);
      chk("to_terr_clr",  {31'd0, timeout_error}, 32'd0);
      send_word(32'h00000001);
      send_word(32'h12345678);
      chk("to_next_strobe", {31'd0, write_strobe}, 32'd1);
      chk("to_next_data",   write_data, 32'h12345678);
      if (CK) send_word(32'h12345678);
      chk("to_next_done",   {31'd0, done}, 32'd1);

      // ---------------- reset mid-word in DATA ----------------
      send_word(32'hFAB0FAB1);
      send_word(32'h00000001);
      send(8'h01);
      send(8'h02);
      snap = strobe_cnt;
      #2;
      rst = 1'b1;
      #1;
      chk("mr_ready",  {31'd0, byte_ready}, 32'd0);
      chk("mr_wdata",  write_data, 32'd0);
      chk("mr_active", {31'd0, active}, 32'd0);
      chk("mr_count",  {16'd0, word_count}, 32'd0);
      byte_valid = 1'b1;
      byte_data  = 8'h03;
      repeat (2) @(posedge clk);
      #1;
      chk("mr_strobe", {31'd0, write_strobe}, 32'd0);
      byte_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("mr_no_strobe", strobe_cnt, snap);
      chk("mr_ready_up",  {31'd0, byte_ready}, 32'd1);
      send_word(32'hFAB0FAB1);
      chk("mr_active_up", {31'd0, active}, 32'd1);
      send_word(32'h00000001);
      send_word(32'hCAFEF00D);
      chk("mr_strobe_new", {31'd0, write_strobe}, 32'd1);
      chk("mr_data_new",   write_data, 32'hCAFEF00D);
      chk("mr_count_new",  {16'd0, word_count}, 32'd1);
      if (CK) send_word(32'hCAFEF00D);

`ifdef PACKER_CHECKSUM_EN
      // ---------------- checksum trailer ----------------
      snap = strobe_cnt;
      send_word(32'hFAB0FAB1);
      send_word(32'h00000002);
      send_word(32'h00000001);
      send_word(32'h00000002);
      send_word(32'h00000003);
      chk("ck_good_done", {31'd0, done}, 32'd1);
      chk("ck_good_err",  {31'd0, checksum_error}, 32'd0);
      chk("ck_good_nstr", strobe_cnt - snap, 32'd2);
      snap = strobe_cnt;
      send_word(32'hFAB0FAB1);
      send_word(32'h00000002);
      send_word(32'h00000001);
      send_word(32'h00000002);
      send_word(32'h00000004);
      chk("ck_bad_done", {31'd0, done}, 32'd1);
      chk("ck_bad_err",  {31'd0, checksum_error}, 32'd1);
      chk("ck_bad_nstr", strobe_cnt - snap, 32'd2);
      send_word(32'hFAB0FAB1);
      chk("ck_err_clr",  {31'd0, checksum_error}, 32'd0);
`else
      chk("cerr_tied", {31'd0, checksum_error}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
`default_nettype wire
